// File: rtl/mod_n_stream_checker.sv
// Framed serial stream checker: tracks a running remainder modulo MOD of either the
// ones count or the MSB-first binary value of each frame, and registers per-frame results.
module mod_n_stream_checker #(
  parameter int MOD   = 3,
  parameter int REM_W = 2,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_in_valid,
  input  logic             i_x,
  input  logic             i_last,
  input  logic             i_mode,
  output logic [REM_W-1:0] o_rem,
  output logic             o_z,
  output logic             o_busy,
  output logic             o_done,
  output logic [REM_W-1:0] o_res_rem,
  output logic             o_res_div,
  output logic [LEN_W-1:0] o_res_len,
  output logic             o_res_ovf
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [REM_W:0]   L_MOD     = (REM_W+1)'(MOD);
  localparam logic [LEN_W-1:0] L_LEN_MAX = '1;

  state_t           r_state, w_state_nxt;
  logic [REM_W-1:0] r_rem, r_res_rem;
  logic [LEN_W-1:0] r_len, r_res_len;
  logic             r_ovf, r_res_ovf, r_mode, r_done;

  logic             w_beat, w_end, w_first, w_mode_eff, w_len_sat, w_ovf_upd;
  logic [REM_W-1:0] w_base, w_rem_upd;
  logic [LEN_W-1:0] w_len_upd;

  // Both modes reduce to one add and one conditional subtract because t < 2*MOD.
  function automatic logic [REM_W-1:0] f_rem_next(input logic [REM_W-1:0] base,
                                                  input logic bit_x,
                                                  input logic val_mode);
    logic [REM_W:0] t;
    if (val_mode) t = {base, bit_x};
    else          t = {1'b0, base} + {{REM_W{1'b0}}, bit_x};
    if (t >= L_MOD) t = t - L_MOD;
    return t[REM_W-1:0];
  endfunction

  always_comb begin
    w_beat      = i_in_valid & ~i_clear;
    w_end       = w_beat & i_last;
    w_first     = (r_state == S_IDLE);
    w_base      = w_first ? '0 : r_rem;
    w_mode_eff  = w_first ? i_mode : r_mode;
    w_rem_upd   = f_rem_next(w_base, i_x, w_mode_eff);
    w_len_sat   = !w_first && (r_len == L_LEN_MAX);
    w_len_upd   = w_first ? LEN_W'(1) : (w_len_sat ? r_len : r_len + LEN_W'(1));
    w_ovf_upd   = !w_first && (r_ovf | w_len_sat);
    w_state_nxt = r_state;
    if (i_clear)     w_state_nxt = S_IDLE;
    else if (w_beat) w_state_nxt = w_end ? S_IDLE : S_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Frame end clears the live state on the same edge that captures the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem     <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_res_rem <= '0;
      r_res_len <= '0;
      r_res_ovf <= 1'b0;
    end else begin
      r_done <= w_end;
      if (i_clear) begin
        r_rem <= '0;
        r_len <= '0;
        r_ovf <= 1'b0;
      end else if (w_beat) begin
        if (w_first) r_mode <= i_mode;
        if (w_end) begin
          r_res_rem <= w_rem_upd;
          r_res_len <= w_len_upd;
          r_res_ovf <= w_ovf_upd;
          r_rem     <= '0;
          r_len     <= '0;
          r_ovf     <= 1'b0;
        end else begin
          r_rem <= w_rem_upd;
          r_len <= w_len_upd;
          r_ovf <= w_ovf_upd;
        end
      end
    end
  end

  assign o_rem     = r_rem;
  assign o_z       = (r_rem == '0);
  assign o_busy    = (r_state == S_RUN);
  assign o_done    = r_done;
  assign o_res_rem = r_res_rem;
  assign o_res_div = (r_res_rem == '0);
  assign o_res_len = r_res_len;
  assign o_res_ovf = r_res_ovf;

endmodule

// File: doc/mod_n_stream_checker.md
# mod_n_stream_checker

Parametrised successor to the team's mod-3 ones-count Moore FSM. It evaluates framed serial bitstreams against a configurable modulus `MOD`, in one of two modes selected per frame:
- Ones-count mode: the number of 1 bits mod `MOD`.
- Value mode: the MSB-first binary value mod `MOD`.

It exposes a live divisibility flag and registers a per-frame result, with beat count, at frame end. It sits between the serial front-end and the status/register block.

## Interface
- `MOD`, 3, modulus; legal range 2..255.
- `REM_W`, 2, remainder width; must satisfy 2^REM_W >= MOD.
- `LEN_W`, 8, beat-counter width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous abort of the current frame.
- `in_valid` in 1: `x` (and `last`) valid this cycle.
- `x` in 1: serial data bit.
- `last` in 1: final beat of the frame; qualified by `in_valid`.
- `mode` in 1: 0 = ones-count, 1 = value; sampled only on the first beat of a frame.
- `rem` out REM_W: live remainder.
- `z` out 1: live Moore flag, `rem == 0`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse marking a completed frame.
- `res_rem` out REM_W: final remainder of the last completed frame.
- `res_div` out 1: `res_rem == 0`.
- `res_len` out LEN_W: beats in the last completed frame, saturated.
- `res_ovf` out 1: the beat count of the last completed frame saturated.

## Operation
- FSM has two states, IDLE and RUN. Reset state is IDLE.
- Reset values:
  - `rem`=0, `z`=1, `busy`=0, `done`=0.
  - `res_rem`=0, `res_div`=1, `res_len`=0, `res_ovf`=0.
  - Internal `mode_q`=0 and beat count=0.
- Beat: a cycle with `in_valid`=1 and `clear`=0. No other cycle alters state.
- Remainder update per beat (from `rem`, or from 0 on the first beat of a frame):
  - Ones mode: if x=1, then rem+1, wrapping to 0 when it reaches MOD. If x=0, rem is held.
  - Value mode: t = 2*rem + x, computed at REM_W+1 bits. Result is t-MOD when t >= MOD, else t. A single conditional subtract is sufficient because t < 2*MOD.
- IDLE + beat:
  - Latch `mode` into `mode_q`.
  - Apply the update from a remainder of 0.
  - Set beat count to 1.
  - Go to RUN, unless `last`=1, in which case end the frame.
- RUN + beat:
  - Apply the update using `mode_q`; the `mode` pin is ignored.
  - Increment the beat count, saturating at 2^LEN_W-1. The overflow flag is sticky once the count would exceed that value.
  - If `last`=1, end the frame.
- Frame end, on the accepting edge:
  - `res_rem` = updated remainder; `res_div` = (`res_rem` == 0).
  - `res_len` = updated beat count; `res_ovf` = overflow flag.
  - Next state is IDLE.
  - `rem`, beat count and overflow flag clear to 0.
  - `done` = 1.
- `done` is a registered pulse: high for exactly the cycle after the ending edge, otherwise 0. Back-to-back frames produce back-to-back `done` pulses.
- `busy` = (state == RUN).
- `clear`:
  - Has priority over `in_valid`.
  - Forces IDLE and sets `rem`, beat count and overflow flag to 0.
  - Does not assert `done`.
  - Leaves `res_*` and any `done` pulse already in flight untouched.
- `reset` asserted mid-frame: all registers go to their reset values immediately. The partial frame is discarded and produces no result.
- `in_valid`=0 cycles (gaps) inside a frame hold all state.

## Timing
- Live `rem` and `z` reflect a beat on the edge that accepts it (1-cycle latency). `z` is decoded combinationally from the `rem` register only, so the block remains Moore.
- Frame results appear 1 cycle after the last beat is sampled. `res_*` are stable from the `done` cycle until the next frame end.
- A new frame may start in the cycle immediately after `last`; no dead cycle is required.
- The critical path is adder → compare → mux on a REM_W+1-bit datapath; no multipliers or dividers are used.

## Test plan
- Ones mode, MOD=3: beats 1,0,1,1 with `last` on the 4th → `done` one cycle later with `res_rem`=0, `res_div`=1, `res_len`=4. Live `rem` sequence is 1,1,2,0.
- Value mode, MOD=5:
  - Beats 1,1,0,0,1 (value 25) → `res_rem`=0, `res_div`=1, `res_len`=5.
  - Next frame 1,1,0,1 (value 13) starting the cycle after → `res_rem`=3, `res_div`=0.
- Single-beat frame (`last` on the first beat, x=1, ones mode, MOD=3) → `res_rem`=1, `res_len`=1, `busy` never asserted. Also: `mode` toggled mid-frame has no effect on the result; `in_valid` gaps do not change `rem`.
- `clear` asserted on the 3rd beat of a frame, with `in_valid` high in the same cycle → no `done`, `rem`=0, `busy`=0, `res_*` keep the previous frame's values.
- `reset` pulsed asynchronously mid-frame (between edges) → all outputs at reset values before the next edge; next frame computes correctly from 0.
- LEN_W=4, a 20-beat frame of all 1s (ones mode, MOD=3) → `res_len`=15, `res_ovf`=1, `res_rem`=2. A following 3-beat frame → `res_ovf`=0, `res_len`=3.
